adc_ltc2308_scan_ctrl: RTL and testbench
========================================

Name: adc_ltc2308_scan_ctrl

Overview:
- Sequencer for the on-board 8-channel, 12-bit LTC2308 SPI ADC on the DE0-Nano-SoC / Atlas boards.
- Autonomously scans the enabled channels in round-robin order and handles the ADC's one-frame config/result pipeline.
- Holds the latest result per channel in a register file that the hm2 bus read path samples.
- Sits beside the hm2 core and drives the ADC pins directly.

Parameters:
- ConvCycles, 80, clk cycles to wait after CONVST for conversion (≥1.6 µs at 50 MHz).
- ConvstCycles, 2, clk cycles CONVST is held high (≥40 ns).
- SckDiv, 2, clk cycles per SCK half-period (SCK = clk/(2*SckDiv)); must be ≥1.
- GapCycles, 2, idle clk cycles between frames.
- NumChan, 8, number of ADC channels; fixed at 8 for this part.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable, level-sensitive.
- chan_mask  in  8  enabled channels; bit i = channel i.
- rd_addr  in  3  result register select.
- rd_data  out  16  {valid, 3'b000, result[11:0]} for rd_addr; combinational from the register file.
- busy  out  1  high while not in IDLE.
- scan_done  out  1  one-cycle pulse when the highest enabled channel's result is written.
- adc_convst  out  1  ADC CONVST.
- adc_sck  out  1  ADC SCK.
- adc_sdi  out  1  ADC config input.
- adc_sdo  in  1  ADC data output.

Behaviour:
- Reset state: state=IDLE; adc_convst=0, adc_sck=0, adc_sdi=0, busy=0, scan_done=0; all results and valid bits 0; prev_ch=0; first=1.
- States: IDLE → CONVST → WAIT → SHIFT → GAP → CONVST…
- IDLE: when enable=1 and chan_mask≠0, go to CONVST next cycle. cur_ch = lowest set bit of chan_mask. first=1.
- CONVST: adc_convst=1 for ConvstCycles, then WAIT.
- WAIT: adc_convst=0 for ConvCycles, then SHIFT.
- SHIFT: 12 SCK periods, MSB first.
  - adc_sdi is updated while SCK is low, to config-word bit k for k=0..5; it is 0 for bits 6..11.
  - Config word = {S/D=1, O/S=cur_ch[0], S1=cur_ch[2], S0=cur_ch[1], UNI=1, SLP=0}.
  - adc_sdo is sampled on the clk edge at which adc_sck rises; shift register shifts left.
  - adc_sck returns low after the 12th high phase; then GAP.
- Pipeline: the data shifted in during a frame belongs to the config sent in the previous frame (prev_ch).
- GAP entry:
  - If first=0: result[prev_ch] ← shift[11:0] and valid[prev_ch] ← 1.
  - first is cleared in all cases.
  - prev_ch ← cur_ch.
  - cur_ch ← next set bit of chan_mask above cur_ch, wrapping to the lowest set bit.
  - scan_done pulses in the same cycle a result is written for the highest set bit of chan_mask.
- GAP: hold GapCycles. Then:
  - CONVST if enable=1 and chan_mask≠0;
  - else IDLE, with pins idle and the last in-flight result discarded.
- chan_mask is sampled only at GAP entry and at IDLE exit. A change mid-frame takes effect at the next channel selection.
- If cur_ch is cleared from the mask, the next-channel search still works from cur_ch's index.
- Single enabled channel: cur_ch stays constant; every frame after the first writes it.
- enable deasserted mid-frame: the frame completes, including the result write, then the controller goes to IDLE. No truncated SPI transfer.
- Results and valid bits persist across IDLE; they are cleared only by reset.
- reset_n asserted mid-frame: all outputs go to reset values immediately; no partial result write.
- Frame length = ConvstCycles + ConvCycles + 24*SckDiv + GapCycles = 132 clk cycles at defaults.

Test Plan:
- Reset, then enable=1, chan_mask=8'h01, ADC model returns 12'hA5C for ch0.
  - Frame 1 writes nothing.
  - At end of frame 2, rd_addr=0 gives rd_data=16'h8A5C; scan_done pulses once per frame from frame 2 on.
- chan_mask=8'b1010_0100, model returns 12'h100+ch.
  - SDI config sequence is ch2, ch5, ch7, ch2…
  - Results land as result[2]=12'h102, result[5]=12'h105, result[7]=12'h107.
  - scan_done pulses only on ch7 writes.
- Timing check at defaults: CONVST high exactly 2 cycles, 80-cycle WAIT, SCK period 4 cycles, 12 SCK rising edges, frame period 132 cycles.
- Drop enable at cycle 100 of a frame: 12 SCK edges still complete, result written, then busy=0 and all pins low.
- Assert reset_n low during SHIFT: adc_sck/adc_convst go 0 the same cycle and every rd_data reads 16'h0000.
- chan_mask=0 with enable=1: busy stays 0 and adc_convst never rises over 1000 cycles.

Source files
------------

// File: rtl/adc_ltc2308_scan_ctrl.sv
// Round-robin scan sequencer for the LTC2308 8-channel SPI ADC.
// Tracks the ADC's one-frame config/result pipeline and keeps the latest result per channel.
module adc_ltc2308_scan_ctrl #(
  parameter int ConvCycles   = 80,
  parameter int ConvstCycles = 2,
  parameter int SckDiv       = 2,
  parameter int GapCycles    = 2,
  parameter int NumChan      = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NumChan-1:0]         chan_mask,
  input  logic [$clog2(NumChan)-1:0] rd_addr,
  output logic [15:0]                rd_data,
  output logic                       busy,
  output logic                       scan_done,
  output logic                       adc_convst,
  output logic                       adc_sck,
  output logic                       adc_sdi,
  input  logic                       adc_sdo
);

  localparam int ChW = $clog2(NumChan);

  localparam logic [15:0] ConvstLast = 16'(ConvstCycles - 1);
  localparam logic [15:0] ConvLast   = 16'(ConvCycles - 1);
  localparam logic [15:0] HalfLast   = 16'(SckDiv - 1);
  localparam logic [15:0] GapLast    = 16'(GapCycles - 1);
  localparam logic [3:0]  LastBit    = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVST,
    S_WAIT,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state;
  logic [15:0]      cnt;
  logic [3:0]       bit_idx;
  logic [11:0]      shift_reg;
  logic [ChW-1:0]   cur_ch;
  logic [ChW-1:0]   prev_ch;
  logic             first;
  logic [11:0]      result [NumChan];
  logic [NumChan-1:0] valid;

  function automatic logic [ChW-1:0] lowest_set(input logic [NumChan-1:0] m);
    lowest_set = '0;
    for (int i = NumChan - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = ChW'(i);
    end
  endfunction

  function automatic logic [ChW-1:0] highest_set(input logic [NumChan-1:0] m);
    highest_set = '0;
    for (int i = 0; i < NumChan; i++) begin
      if (m[i]) highest_set = ChW'(i);
    end
  endfunction

  // Search strictly above the current index even if that channel has left the mask.
  function automatic logic [ChW-1:0] next_set(input logic [NumChan-1:0] m,
                                              input logic [ChW-1:0] cur);
    logic found;
    next_set = lowest_set(m);
    found    = 1'b0;
    for (int i = 0; i < NumChan; i++) begin
      if (!found && (i > int'(cur)) && m[i]) begin
        next_set = ChW'(i);
        found    = 1'b1;
      end
    end
  endfunction

  // Config word MSB first: S/D, O/S, S1, S0, UNI, SLP; remaining SCK bits carry zero.
  function automatic logic cfg_bit(input logic [ChW-1:0] ch, input logic [3:0] k);
    case (k)
      4'd0:    cfg_bit = 1'b1;
      4'd1:    cfg_bit = ch[0];
      4'd2:    cfg_bit = ch[2];
      4'd3:    cfg_bit = ch[1];
      4'd4:    cfg_bit = 1'b1;
      default: cfg_bit = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      cur_ch     <= '0;
      prev_ch    <= '0;
      first      <= 1'b1;
      valid      <= '0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
      adc_convst <= 1'b0;
      adc_sck    <= 1'b0;
      adc_sdi    <= 1'b0;
      for (int i = 0; i < NumChan; i++) result[i] <= '0;
    end else begin
      scan_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          adc_convst <= 1'b0;
          adc_sck    <= 1'b0;
          adc_sdi    <= 1'b0;
          busy       <= 1'b0;
          first      <= 1'b1;
          cnt        <= '0;
          if (enable && (|chan_mask)) begin
            state      <= S_CONVST;
            cur_ch     <= lowest_set(chan_mask);
            adc_convst <= 1'b1;
            busy       <= 1'b1;
          end
        end

        S_CONVST: begin
          if (cnt == ConvstLast) begin
            state      <= S_WAIT;
            adc_convst <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_WAIT: begin
          if (cnt == ConvLast) begin
            state   <= S_SHIFT;
            cnt     <= '0;
            bit_idx <= '0;
            adc_sdi <= cfg_bit(cur_ch, 4'd0);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        // SDO is captured on the edge that raises SCK; SDI moves on the edge that lowers it.
        S_SHIFT: begin
          if (cnt == HalfLast) begin
            cnt <= '0;
            if (!adc_sck) begin
              adc_sck   <= 1'b1;
              shift_reg <= {shift_reg[10:0], adc_sdo};
            end else begin
              adc_sck <= 1'b0;
              if (bit_idx == LastBit) begin
                state   <= S_GAP;
                adc_sdi <= 1'b0;
                if (!first) begin
                  result[prev_ch] <= shift_reg;
                  valid[prev_ch]  <= 1'b1;
                  if (prev_ch == highest_set(chan_mask)) scan_done <= 1'b1;
                end
                first   <= 1'b0;
                prev_ch <= cur_ch;
                cur_ch  <= next_set(chan_mask, cur_ch);
              end else begin
                bit_idx <= bit_idx + 4'd1;
                adc_sdi <= cfg_bit(cur_ch, bit_idx + 4'd1);
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_GAP: begin
          if (cnt == GapLast) begin
            cnt <= '0;
            if (enable && (|chan_mask)) begin
              state      <= S_CONVST;
              adc_convst <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          adc_convst <= 1'b0;
          adc_sck    <= 1'b0;
          adc_sdi    <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data = {valid[rd_addr], 3'b000, result[rd_addr]};

endmodule

// File: tb/tb_adc_ltc2308_scan_ctrl.sv
// Self-checking bench for adc_ltc2308_scan_ctrl with a behavioural LTC2308 model.
// Expected scan order and results come from the mask/value tables, not from the RTL.
module tb_adc_ltc2308_scan_ctrl;

  localparam int ConvCycles   = 80;
  localparam int ConvstCycles = 2;
  localparam int SckDiv       = 2;
  localparam int GapCycles    = 2;
  localparam int FrameCycles  = ConvstCycles + ConvCycles + 24 * SckDiv + GapCycles;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  chan_mask = 8'h00;
  logic [2:0]  rd_addr = 3'd0;
  logic [15:0] rd_data;
  logic        busy, scan_done, adc_convst, adc_sck, adc_sdi;
  logic        adc_sdo = 1'b0;

  int checks = 0;
  int errors = 0;

  adc_ltc2308_scan_ctrl #(
    .ConvCycles(ConvCycles), .ConvstCycles(ConvstCycles), .SckDiv(SckDiv),
    .GapCycles(GapCycles), .NumChan(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .chan_mask(chan_mask),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .scan_done(scan_done),
    .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
  );

  always #10 clk = ~clk;

  // Pin activity monitor, sampled on the falling clock edge.
  int   cyc = 0, convstRises = 0, doneCount = 0, sckRises = 0, frameSckRises = 0;
  int   convstLen = 0, convstLenDone = 0, lastConvstRise = -1, framePeriod = 0;
  int   convstFall = 0, lastSckRise = 0, sckPeriod = 0, firstRiseDelay = 0;
  logic prevConvst = 1'b0, prevSck = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (adc_convst && !prevConvst) begin
      if (lastConvstRise >= 0) framePeriod = cyc - lastConvstRise;
      lastConvstRise = cyc;
      frameSckRises  = sckRises;
      sckRises       = 0;
      convstLen      = 0;
      convstRises++;
    end
    if (adc_convst) convstLen++;
    if (!adc_convst && prevConvst) begin
      convstLenDone = convstLen;
      convstFall    = cyc;
    end
    if (adc_sck && !prevSck) begin
      sckRises++;
      if (sckRises == 1) firstRiseDelay = cyc - convstFall;
      else sckPeriod = cyc - lastSckRise;
      lastSckRise = cyc;
    end
    if (scan_done) doneCount++;
    prevConvst = adc_convst;
    prevSck    = adc_sck;
  end

  // LTC2308 model: a conversion started by CONVST uses the config clocked in during the previous frame.
  logic [11:0] adcValue [8];
  logic [11:0] capWord = 12'h000;
  logic [11:0] sdoWord = 12'h000;
  int          capCnt = 0;
  int          badCfg = 0;
  logic [2:0]  cfgQueue [$];

  always @(posedge adc_sck) begin
    if (capCnt < 12) begin
      capWord = {capWord[10:0], adc_sdi};
      capCnt++;
    end
  end

  always @(posedge adc_convst) begin : convModel
    logic [2:0] ch;
    if (capCnt == 12) begin
      ch = {capWord[9], capWord[8], capWord[10]};
      if (!capWord[11] || !capWord[7] || capWord[6] || (capWord[5:0] != 6'd0)) badCfg++;
      cfgQueue.push_back(ch);
      sdoWord = adcValue[ch];
    end else begin
      sdoWord = 12'h000;
    end
    capCnt  = 0;
    adc_sdo = sdoWord[11];
  end

  always @(negedge adc_sck) begin
    sdoWord = {sdoWord[10:0], 1'b0};
    adc_sdo = sdoWord[11];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] mask);
    enable    = en;
    chan_mask = mask;
  endtask

  task automatic applyReset();
    enable  = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    capCnt  = 0;
    badCfg  = 0;
    sdoWord = 12'h000;
    adc_sdo = 1'b0;
    cfgQueue.delete();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic readReg(input int a, output logic [15:0] d);
    rd_addr = 3'(a);
    #1;
    d = rd_data;
  endtask

  task automatic waitRises(input int target, input int budget, input string tag);
    int k = 0;
    while (convstRises < target && k < budget) begin
      tick();
      k++;
    end
    checkOutput($sformatf("%s_frame_start_reached", tag), convstRises, target);
  endtask

  // Runs a fixed mask for a number of frames and compares against the round-robin model.
  task automatic runScan(input logic [7:0] mask, input int frames, input string tag);
    int          order[$];
    int          seq[$];
    logic [11:0] expRes [8];
    logic        expValid [8];
    int          expDone, hi, base, baseDone;
    logic [15:0] d;
    applyReset();
    for (int i = 0; i < 8; i++) if (mask[i]) order.push_back(i);
    hi = order[order.size() - 1];
    for (int j = 0; j < frames; j++) seq.push_back(order[j % order.size()]);
    for (int i = 0; i < 8; i++) begin
      expRes[i]   = 12'h000;
      expValid[i] = 1'b0;
    end
    expDone = 0;
    for (int j = 0; j < frames - 1; j++) begin
      expRes[seq[j]]   = adcValue[seq[j]];
      expValid[seq[j]] = 1'b1;
      if (seq[j] == hi) expDone++;
    end
    base     = convstRises;
    baseDone = doneCount;
    applyStimulus(1'b1, mask);
    waitRises(base + frames + 1, (frames + 2) * FrameCycles, tag);
    checkOutput($sformatf("%s_cfg_count", tag), cfgQueue.size(), frames);
    for (int j = 0; j < frames && j < cfgQueue.size(); j++)
      checkOutput($sformatf("%s_cfg%0d", tag, j), 32'(cfgQueue[j]), seq[j]);
    checkOutput($sformatf("%s_cfg_fixed_bits", tag), badCfg, 0);
    for (int ch = 0; ch < 8; ch++) begin
      readReg(ch, d);
      checkOutput($sformatf("%s_rd%0d", tag, ch), 32'(d), 32'({expValid[ch], 3'b000, expRes[ch]}));
    end
    checkOutput($sformatf("%s_scan_done_count", tag), doneCount - baseDone, expDone);
    applyStimulus(1'b0, mask);
  endtask

  initial begin
    int          base, baseDone, k;
    logic [15:0] d;
    logic        busySeen, convstSeen;

    // Reset state.
    for (int i = 0; i < 8; i++) adcValue[i] = 12'h000;
    applyReset();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_convst", adc_convst, 0);
    checkOutput("reset_sck", adc_sck, 0);
    checkOutput("reset_sdi", adc_sdi, 0);
    checkOutput("reset_scan_done", scan_done, 0);
    for (int ch = 0; ch < 8; ch++) begin
      readReg(ch, d);
      checkOutput($sformatf("reset_rd%0d", ch), d, 0);
    end

    // Single channel 0, pipeline latency and pin timing.
    for (int i = 0; i < 8; i++) adcValue[i] = 12'hA5C;
    applyReset();
    base     = convstRises;
    baseDone = doneCount;
    applyStimulus(1'b1, 8'h01);
    waitRises(base + 2, 3 * FrameCycles, "t1_f2");
    readReg(0, d);
    checkOutput("t1_frame1_no_write", d, 16'h0000);
    checkOutput("t1_frame1_no_done", doneCount - baseDone, 0);
    waitRises(base + 3, 2 * FrameCycles, "t1_f3");
    readReg(0, d);
    checkOutput("t1_frame2_result", d, 16'h8A5C);
    checkOutput("t1_frame2_done", doneCount - baseDone, 1);
    waitRises(base + 4, 2 * FrameCycles, "t1_f4");
    checkOutput("t1_frame3_done", doneCount - baseDone, 2);
    checkOutput("t1_convst_high_cycles", convstLenDone, ConvstCycles);
    checkOutput("t1_wait_to_first_sck", firstRiseDelay, ConvCycles + SckDiv);
    checkOutput("t1_sck_period", sckPeriod, 2 * SckDiv);
    checkOutput("t1_sck_rises_per_frame", frameSckRises, 12);
    checkOutput("t1_frame_period", framePeriod, FrameCycles);
    checkOutput("t1_busy_running", busy, 1);

    // Three-channel mask, per-channel values.
    for (int i = 0; i < 8; i++) adcValue[i] = 12'(12'h100 + i);
    runScan(8'b1010_0100, 6, "t2");

    // Randomized masks and ADC values.
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 8; i++) adcValue[i] = 12'($urandom_range(0, 4095));
      runScan(8'($urandom_range(1, 255)), $urandom_range(3, 9), $sformatf("rnd%0d", it));
    end

    // Enable dropped during SHIFT: the frame completes and writes, then the controller idles.
    for (int i = 0; i < 8; i++) adcValue[i] = 12'hA5C;
    applyReset();
    base     = convstRises;
    baseDone = doneCount;
    applyStimulus(1'b1, 8'h01);
    waitRises(base + 2, 3 * FrameCycles, "t4");
    repeat (100) tick();
    applyStimulus(1'b0, 8'h01);
    repeat (200) tick();
    checkOutput("t4_sck_rises_completed", sckRises, 12);
    checkOutput("t4_no_new_frame", convstRises - base, 2);
    readReg(0, d);
    checkOutput("t4_result_written", d, 16'h8A5C);
    checkOutput("t4_done_count", doneCount - baseDone, 1);
    checkOutput("t4_idle_pins", {busy, adc_convst, adc_sck, adc_sdi}, 4'b0000);

    // Reset asserted while SCK is high.
    applyReset();
    base = convstRises;
    applyStimulus(1'b1, 8'h01);
    waitRises(base + 3, 4 * FrameCycles, "t5");
    k = 0;
    while (!adc_sck && k < 2 * FrameCycles) begin
      tick();
      k++;
    end
    checkOutput("t5_sck_high_seen", adc_sck, 1);
    readReg(0, d);
    checkOutput("t5_result_before_reset", d, 16'h8A5C);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_sck_cleared", adc_sck, 0);
    checkOutput("t5_convst_cleared", adc_convst, 0);
    checkOutput("t5_busy_cleared", busy, 0);
    for (int ch = 0; ch < 8; ch++) begin
      readReg(ch, d);
      checkOutput($sformatf("t5_rd%0d_cleared", ch), d, 0);
    end

    // Empty mask with enable high never starts a frame.
    applyReset();
    base       = convstRises;
    busySeen   = 1'b0;
    convstSeen = 1'b0;
    applyStimulus(1'b1, 8'h00);
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (busy) busySeen = 1'b1;
      if (adc_convst) convstSeen = 1'b1;
    end
    checkOutput("t6_busy_never", busySeen, 0);
    checkOutput("t6_convst_never", convstSeen, 0);
    checkOutput("t6_no_frames", convstRises - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(90000 * 20);
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
